// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types for the rv SPI slave
package rv_pkg;

  typedef logic [7:0] spi_byte_t;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_slv_state_t;

  localparam int SPI_BITS = 8;

endpackage

// File: rtl/rv_sync.sv
// rtl/rv_sync.sv - N-flop synchronizer with selectable reset value
module rv_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic arstn_i,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      ff <= {N{RST_VAL}};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < N; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/rv_spi_slave.sv
// rtl/rv_spi_slave.sv - SPI mode-0 byte slave with one-deep TX holding register
module rv_spi_slave
  import rv_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter spi_byte_t IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       arstn_i,
  input  logic       spi_sck_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  localparam int FLUSH_CYC = SYNC_STAGES + 1;
  localparam int FLUSH_W   = $clog2(FLUSH_CYC + 1);

  logic sck_s, cs_n_s, mosi_s;
  logic sck_d, cs_n_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  logic [FLUSH_W-1:0] flush_cnt;
  logic               cs_armed;

  spi_slv_state_t state, state_nxt;

  logic       active, load, rx_shift, tx_shift, abort, byte_done;
  logic [2:0] bit_cnt;
  spi_byte_t  rx_sh, tx_sh, hold_data, rx_byte;
  logic       hold_full;

  rv_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .arstn_i(arstn_i), .d(spi_sck_i), .q(sck_s)
  );
  rv_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .arstn_i(arstn_i), .d(spi_cs_n_i), .q(cs_n_s)
  );
  rv_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .arstn_i(arstn_i), .d(spi_mosi_i), .q(mosi_s)
  );

  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      sck_d  <= 1'b0;
      cs_n_d <= 1'b1;
    end else begin
      sck_d  <= sck_s;
      cs_n_d <= cs_n_s;
    end
  end

  // A CS already low when reset releases looks like a falling edge once the
  // synchronizer flushes; only edges after CS has been seen high start a frame.
  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      flush_cnt <= '0;
      cs_armed  <= 1'b0;
    end else if (flush_cnt != FLUSH_W'(FLUSH_CYC)) begin
      flush_cnt <= flush_cnt + FLUSH_W'(1);
    end else if (cs_n_s) begin
      cs_armed <= 1'b1;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = cs_armed & cs_n_d & ~cs_n_s;
  assign cs_rise  = ~cs_n_d & cs_n_s;

  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) state <= SPI_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SPI_IDLE:   if (cs_fall) state_nxt = SPI_ACTIVE;
      SPI_ACTIVE: if (cs_rise) state_nxt = SPI_IDLE;
      default:    state_nxt = SPI_IDLE;
    endcase
  end

  // CS deassertion takes priority over any sck edge seen in the same cycle.
  always_comb begin
    active    = (state == SPI_ACTIVE);
    abort     = active & cs_rise;
    rx_shift  = active & ~cs_rise & sck_rise;
    tx_shift  = active & ~cs_rise & sck_fall & (bit_cnt != 3'd0);
    load      = ((state == SPI_IDLE) & cs_fall) |
                (active & ~cs_rise & sck_fall & (bit_cnt == 3'd0));
    byte_done = rx_shift & (bit_cnt == 3'd7);
    rx_byte   = {rx_sh[6:0], mosi_s};
  end

  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      bit_cnt <= 3'd0;
      rx_sh   <= '0;
    end else if (rx_shift) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sh   <= rx_byte;
    end else if (abort || ((state == SPI_IDLE) && cs_fall)) begin
      bit_cnt <= 3'd0;
      rx_sh   <= '0;
    end
  end

  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      tx_sh         <= '0;
      tx_underrun_o <= 1'b0;
    end else begin
      tx_underrun_o <= load & ~hold_full;
      if (load)          tx_sh <= hold_full ? hold_data : IDLE_BYTE;
      else if (tx_shift) tx_sh <= {tx_sh[6:0], 1'b0};
      else if (abort)    tx_sh <= '0;
    end
  end

  // A write into an empty register wins over a same-cycle load of IDLE_BYTE.
  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (tx_valid_i && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data_i;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn_i) begin
    if (!arstn_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      rx_overrun_o <= 1'b0;
      if (byte_done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= rx_byte;
          rx_valid_o <= 1'b1;
        end else begin
          rx_overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign spi_miso_o    = tx_sh[7];
  assign spi_miso_oe_o = active;
  assign busy_o        = active;
  assign tx_ready_o    = ~hold_full;

endmodule

// File: tb/tb_rv_spi_slave.sv
// tb/tb_rv_spi_slave.sv - randomized directed bench for rv_spi_slave with queue model
module tb_rv_spi_slave;

  logic       clk = 1'b0;
  logic       arstn_i = 1'b0;
  logic       spi_sck_i = 1'b0;
  logic       spi_cs_n_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       spi_miso_o, spi_miso_oe_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b1;
  logic       rx_overrun_o, tx_underrun_o, busy_o;

  rv_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .arstn_i(arstn_i),
    .spi_sck_i(spi_sck_i), .spi_cs_n_i(spi_cs_n_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_overrun_o(rx_overrun_o), .tx_underrun_o(tx_underrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         rx_rises = 0, ovr_n = 0, und_n = 0, rx_n = 0;
  logic [7:0] rx_log [0:255];
  logic       prev_valid = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (rx_valid_o && !prev_valid) rx_rises++;
    prev_valid = rx_valid_o;
    if (rx_valid_o && rx_ready_i) begin
      rx_log[rx_n[7:0]] = rx_data_o;
      rx_n++;
    end
    if (rx_overrun_o)  ovr_n++;
    if (tx_underrun_o) und_n++;
  end

  logic [7:0] tx_q [$];
  int         und_exp = 0;
  logic [7:0] mosi_a [0:7];
  logic [7:0] miso_a [0:7];
  int         rx_base, rise_base, ovr_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_miso"},     spi_miso_o,    1'b0);
    check({pfx, "_oe"},       spi_miso_oe_o, 1'b0);
    check({pfx, "_tx_ready"}, tx_ready_o,    1'b1);
    check({pfx, "_rx_data"},  rx_data_o,     8'h00);
    check({pfx, "_rx_valid"}, rx_valid_o,    1'b0);
    check({pfx, "_overrun"},  rx_overrun_o,  1'b0);
    check({pfx, "_underrun"}, tx_underrun_o, 1'b0);
    check({pfx, "_busy"},     busy_o,        1'b0);
  endtask

  task automatic write_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready_o, 1'b1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    tx_q.push_back(d);
    check("tx_ready_after_write", tx_ready_o, 1'b0);
  endtask

  // Mode-0 master: MOSI changes with sck low, MISO sampled just before the
  // rising edge; the final sck fall coincides with CS deassertion.
  task automatic frame(input int nbytes, input int nbits_last);
    spi_cs_n_i = 1'b0;
    repeat (8) @(negedge clk);
    check("oe_in_frame", spi_miso_oe_o, 1'b1);
    check("busy_in_frame", busy_o, 1'b1);
    for (int b = 0; b < nbytes; b++) begin
      int nb = (b == nbytes - 1) ? nbits_last : 8;
      miso_a[b] = 8'h00;
      for (int i = 0; i < nb; i++) begin
        spi_mosi_i = mosi_a[b][7-i];
        repeat (4) @(negedge clk);
        miso_a[b][7-i] = spi_miso_o;
        spi_sck_i = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck_i = 1'b0;
        if (b == nbytes - 1 && i == nb - 1) spi_cs_n_i = 1'b1;
      end
    end
    repeat (8) @(negedge clk);
    check("oe_after_frame", spi_miso_oe_o, 1'b0);
    check("busy_after_frame", busy_o, 1'b0);
  endtask

  task automatic check_miso(input int nbytes, input int nbits_last);
    for (int b = 0; b < nbytes; b++) begin
      int         nb = (b == nbytes - 1) ? nbits_last : 8;
      logic [7:0] mask = 8'hFF << (8 - nb);
      logic [7:0] exp;
      if (tx_q.size() > 0) exp = tx_q.pop_front();
      else begin
        exp = 8'hFF;
        und_exp++;
      end
      check("miso_byte", miso_a[b] & mask, exp & mask);
    end
    check("underrun_count", und_n, und_exp);
  endtask

  task automatic snap();
    rx_base   = rx_n;
    rise_base = rx_rises;
    ovr_base  = ovr_n;
  endtask

  task automatic check_rx(input int nexp);
    check("rx_count", rx_n - rx_base, nexp);
    for (int b = 0; b < nexp; b++) check("rx_byte", rx_log[(rx_base + b) % 256], mosi_a[b]);
    check("overrun_count", ovr_n - ovr_base, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    arstn_i = 1'b1;
    repeat (10) @(negedge clk);

    // Preloaded byte against a single received byte
    write_tx(8'hA5);
    snap();
    mosi_a[0] = 8'h3C;
    frame(1, 8);
    check_miso(1, 8);
    check_rx(1);
    check("single_rise", rx_rises - rise_base, 1);

    // Three-byte frame with nothing queued
    snap();
    mosi_a[0] = 8'h11; mosi_a[1] = 8'h22; mosi_a[2] = 8'h33;
    frame(3, 8);
    check_miso(3, 8);
    check_rx(3);

    // Consumer stalled: second byte is dropped
    rx_ready_i = 1'b0;
    snap();
    mosi_a[0] = 8'h55; mosi_a[1] = 8'hAA;
    frame(2, 8);
    check_miso(2, 8);
    check("ovr_data", rx_data_o, 8'h55);
    check("ovr_valid", rx_valid_o, 1'b1);
    check("ovr_pulses", ovr_n - ovr_base, 1);
    rx_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rx_valid_drained", rx_valid_o, 1'b0);

    // Partial byte then a full one
    snap();
    mosi_a[0] = 8'hF0;
    frame(1, 5);
    check_miso(1, 5);
    check("partial_no_rx", rx_rises - rise_base, 0);
    check("partial_no_ovr", ovr_n - ovr_base, 0);
    snap();
    mosi_a[0] = 8'h0F;
    frame(1, 8);
    check_miso(1, 8);
    check_rx(1);

    // Back-to-back TX writes while the frame runs
    snap();
    write_tx(8'h01);
    mosi_a[0] = 8'hC3; mosi_a[1] = 8'h7E; mosi_a[2] = 8'h81;
    fork
      frame(3, 8);
      begin
        write_tx(8'h02);
        write_tx(8'h03);
      end
    join
    check_miso(3, 8);
    check_rx(3);

    // Random frames with optional preload
    for (int it = 0; it < 5; it++) begin
      int nbytes = $urandom_range(1, 3);
      snap();
      if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
      for (int b = 0; b < nbytes; b++) mosi_a[b] = 8'($urandom);
      frame(nbytes, 8);
      check_miso(nbytes, 8);
      check_rx(nbytes);
    end

    // Reset in the middle of a byte
    snap();
    write_tx(8'h5A);
    spi_cs_n_i = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      spi_mosi_i = 1'($urandom);
      repeat (4) @(negedge clk);
      spi_sck_i = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck_i = 1'b0;
    end
    repeat (2) @(negedge clk);
    arstn_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tx_q.delete();
    repeat (3) @(negedge clk);
    arstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      spi_mosi_i = 1'($urandom);
      repeat (4) @(negedge clk);
      spi_sck_i = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck_i = 1'b0;
    end
    check("postreset_idle", busy_o, 1'b0);
    check("postreset_no_rx", rx_rises - rise_base, 0);
    spi_cs_n_i = 1'b1;
    repeat (8) @(negedge clk);
    snap();
    mosi_a[0] = 8'($urandom);
    frame(1, 8);
    check_miso(1, 8);
    check_rx(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_spi_slave.md
RV_SPI_SLAVE -- requirements
Module: rv_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for spi_sck_i, spi_cs_n_i and spi_mosi_i.
REQ-002 SHALL have parameter IDLE_BYTE, default 8'hFF, meaning the byte shifted out when no TX data is queued.
REQ-003 clk  input  1  system clock.
REQ-004 arstn_i  input  1  reset: asynchronous, active-low.
REQ-005 spi_sck_i  input  1  SPI clock from the master, asynchronous to clk.
REQ-006 spi_cs_n_i  input  1  chip select, active-low.
REQ-007 spi_mosi_i  input  1  master-out data.
REQ-008 spi_miso_o  output  1  slave-out data.
REQ-009 spi_miso_oe_o  output  1  MISO drive enable; high only while the synchronized CS is asserted.
REQ-010 tx_data_i  input  8  next byte to transmit.
REQ-011 tx_valid_i  input  1  TX byte offered.
REQ-012 tx_ready_o  output  1  TX holding register empty.
REQ-013 rx_data_o  output  8  last received byte.
REQ-014 rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-015 rx_ready_i  input  1  consumer accepts rx_data_o.
REQ-016 rx_overrun_o  output  1  one-cycle pulse: a received byte was dropped.
REQ-017 tx_underrun_o  output  1  one-cycle pulse: IDLE_BYTE was loaded because the holding register was empty.
REQ-018 busy_o  output  1  synchronized CS asserted.

Function
REQ-019 SHALL implement SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
REQ-020 SHALL pass sck, cs_n and mosi through SYNC_STAGES flops; all edge detection uses the synchronized signals compared with a one-cycle-delayed copy.
REQ-021 Operation is guaranteed for f_clk >= 8 x f_sck; behaviour at lower ratios is not defined.
REQ-022 FSM states: IDLE (CS high) and ACTIVE (CS low); IDLE->ACTIVE on the synchronized CS falling edge; ACTIVE->IDLE on the synchronized CS rising edge.
REQ-023 On IDLE->ACTIVE: bit counter = 0; shift register loaded from the holding register, or from IDLE_BYTE with tx_underrun_o pulsed if empty; spi_miso_o = bit 7 of the loaded byte on the next cycle.
REQ-024 On each synchronized sck rising edge in ACTIVE: shift mosi into the RX shift register LSB; bit counter increments modulo 8.
REQ-025 On each synchronized sck falling edge in ACTIVE: spi_miso_o advances to the next TX bit; after the 8th rising edge, the falling edge instead loads the next TX byte (holding register or IDLE_BYTE, per REQ-023) and drives its bit 7.
REQ-026 Bit counter wrap 7->0 on a rising edge completes a byte: if rx_valid_o is low, or rx_ready_i is high in the same cycle, rx_data_o <= assembled byte and rx_valid_o = 1 on the next cycle; otherwise drop the byte, keep rx_data_o, and pulse rx_overrun_o.
REQ-027 rx_valid_o clears on the cycle after rx_valid_o && rx_ready_i, unless a byte completes in that same cycle, in which case it stays high with the new data.
REQ-028 tx_ready_o = holding register empty; tx_valid_i && tx_ready_o loads the holding register; tx_ready_o goes low on the next cycle.
REQ-029 A load into the shift register empties the holding register; tx_ready_o rises on the next cycle; a same-cycle write and load is accepted (write wins, register stays full).
REQ-030 CS deasserting mid-byte: discard partial RX bits (no rx_valid_o, no overrun), discard the in-flight TX byte (not re-sent), reset the bit counter, drop spi_miso_oe_o on the next cycle; the holding register is untouched.
REQ-031 sck edges while in IDLE are ignored.

Reset
REQ-032 On arstn_i low: FSM = IDLE; bit counter = 0; shift registers = 0; holding register empty; synchronizer flops = sck 0 / cs_n 1 / mosi 0.
REQ-033 Output values under reset: spi_miso_o = 0, spi_miso_oe_o = 0, tx_ready_o = 1, rx_data_o = 0, rx_valid_o = 0, rx_overrun_o = 0, tx_underrun_o = 0, busy_o = 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release, the first byte is received only after a new CS falling edge.

Structure
REQ-035 rv_pkg SHALL hold typedef spi_byte_t (logic [7:0]) and the SPI FSM state enum spi_slv_state_t.
REQ-036 One sub-module SHALL be used: rv_sync (parameterized N-flop synchronizer with a reset-value parameter), instantiated once per SPI input.

Verification
REQ-037 f_clk = 8 x f_sck, tx 8'hA5 preloaded, master sends 8'h3C -> MISO shows A5 MSB first, rx_data_o = 8'h3C, one rx_valid_o rise, no pulses.
REQ-038 No TX preload, 3-byte frame 11/22/33 -> MISO = FF FF FF, tx_underrun_o pulses 3 times, rx bytes 11, 22, 33 with rx_ready_i held high.
REQ-039 rx_ready_i held low, master sends 55 then AA -> rx_data_o stays 55, rx_valid_o stays high, exactly one rx_overrun_o pulse.
REQ-040 CS raised after 5 bits of 8'hF0, then a new frame with 8'h0F -> no rx_valid_o for the partial byte, then rx_data_o = 0F; spi_miso_oe_o low between frames.
REQ-041 TX writes 01, 02, 03 issued back-to-back against tx_ready_o over a 3-byte frame -> MISO = 01 02 03 with no underrun.
REQ-042 arstn_i pulsed at bit 4 of a byte -> all outputs at their REQ-033 values; the next full frame is received correctly.
